// File: rtl/func_dispatch.sv
// rtl/func_dispatch.sv - operand FIFO and single-op launcher for the func datapath
module func_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [7:0]  op_x1,
  input  logic [7:0]  op_x2,
  output logic        op_ready,
  output logic [7:0]  f_x1,
  output logic [7:0]  f_x2,
  output logic        f_start,
  input  logic        f_busy,
  input  logic [3:0]  f_y,
  output logic        res_valid,
  output logic [3:0]  res_y,
  input  logic        res_ready,
  output logic [15:0] done_cnt,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [9:0] TMO = 10'(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;
  localparam logic [1:0] RUN    = 2'd3;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic          ack_cnt;
  logic [9:0]    timer;
  logic          push;
  logic          pop;

  assign op_ready = (count != FULL_CNT);
  assign push     = op_valid & op_ready;
  // Only one op may be outstanding: the result register must be empty before a pop.
  assign pop      = (state == IDLE) && (count != '0) && !res_valid;

  // Operand storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {op_x1, op_x2};
  end

  // Wrap-around pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Launch FSM: pop, pulse start, wait for busy, then capture the result or flag a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      f_x1      <= '0;
      f_x2      <= '0;
      f_start   <= 1'b0;
      res_valid <= 1'b0;
      res_y     <= '0;
      done_cnt  <= '0;
      err       <= 1'b0;
      ack_cnt   <= 1'b0;
      timer     <= '0;
    end else begin
      f_start <= (state == LAUNCH);
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            f_x1  <= mem[rd_ptr][15:8];
            f_x2  <= mem[rd_ptr][7:0];
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          ack_cnt <= 1'b0;
          state   <= ACK;
        end
        ACK: begin
          if (f_busy) begin
            timer <= 10'd1;
            state <= RUN;
          end else if (ack_cnt) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            ack_cnt <= 1'b1;
          end
        end
        default: begin
          if (!f_busy) begin
            res_y     <= f_y;
            res_valid <= 1'b1;
            done_cnt  <= done_cnt + 16'd1;
            state     <= IDLE;
          end else if (timer == TMO) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer + 10'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func_dispatch.sv
// tb/tb_func_dispatch.sv - scoreboard bench for func_dispatch with a behavioural func stub
module tb_func_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [7:0]  op_x1 = '0;
  logic [7:0]  op_x2 = '0;
  logic        op_ready;
  logic [7:0]  f_x1;
  logic [7:0]  f_x2;
  logic        f_start;
  logic        f_busy = 1'b0;
  logic [3:0]  f_y = '0;
  logic        res_valid;
  logic [3:0]  res_y;
  logic        res_ready = 1'b1;
  logic [15:0] done_cnt;
  logic        err;

  int          n_checks = 0;
  int          n_fail = 0;
  int          start_cnt = 0;
  int          sc;
  logic [3:0]  exp_q [$];
  bit          dead = 1'b0;
  int          lat = 3;
  int          fcnt = 0;
  logic [3:0]  fres = '0;

  func_dispatch #(.DEPTH(4), .TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_x1(op_x1), .op_x2(op_x2), .op_ready(op_ready),
    .f_x1(f_x1), .f_x2(f_x2), .f_start(f_start), .f_busy(f_busy), .f_y(f_y),
    .res_valid(res_valid), .res_y(res_y), .res_ready(res_ready),
    .done_cnt(done_cnt), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int cbrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Func stub: samples start, raises busy next cycle, drops it with y after lat cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      f_busy <= 1'b0;
      f_y    <= '0;
      fcnt   <= 0;
    end else if (f_busy) begin
      if (fcnt == 0) begin
        f_busy <= 1'b0;
        f_y    <= fres;
      end else begin
        fcnt <= fcnt - 1;
      end
    end else if (f_start && !dead) begin
      f_busy <= 1'b1;
      fcnt   <= lat;
      fres   <= 4'(cbrt(int'(f_x1) + cbrt(int'(f_x2))));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start-pulse counter and result scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && f_start) start_cnt++;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h expected none", res_y);
      end else begin
        check("res_y", 32'(res_y), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] e, input bit has_e);
    int w = 0;
    op_valid = 1'b1;
    op_x1 = a;
    op_x2 = b;
    while (!op_ready && w < 200) begin
      cycles(1);
      w++;
    end
    if (!op_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got op_ready 0 expected 1");
    end else begin
      @(posedge clk);
      if (has_e) exp_q.push_back(e);
      #1;
    end
    op_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || res_valid) && w < 500) begin
      cycles(1);
      w++;
    end
    if (exp_q.size() != 0 || res_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic wait_res_valid();
    int w = 0;
    while (!res_valid && w < 200) begin
      cycles(1);
      w++;
    end
    check("res_valid_arrives", 32'(res_valid), 32'd1);
  endtask

  task automatic wait_busy();
    int w = 0;
    while (!f_busy && w < 200) begin
      cycles(1);
      w++;
    end
    check("busy_arrives", 32'(f_busy), 32'd1);
  endtask

  initial begin
    #1;
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_f_start", 32'(f_start), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_f_x", 32'({f_x1, f_x2}), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // 1: single op, start latency and one pulse
    sc = start_cnt;
    push(8'd0, 8'd8, 4'd1, 1'b1);
    cycles(1);
    check("latency_plus1", 32'(f_start), 32'd0);
    cycles(1);
    check("latency_plus2", 32'(f_start), 32'd1);
    check("f_operands", 32'({f_x1, f_x2}), 32'h0008);
    drain();
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_one_start", 32'(start_cnt - sc), 32'd1);

    // 2: back-to-back burst, in-order results
    push(8'd62, 8'd27, 4'd4, 1'b1);
    push(8'd255, 8'd255, 4'd6, 1'b1);
    push(8'd0, 8'd0, 4'd0, 1'b1);
    push(8'd7, 8'd1, 4'd2, 1'b1);
    drain();
    check("t2_done_cnt", 32'(done_cnt), 32'd5);

    // 3: consumer stalls; no second launch, FIFO fills
    res_ready = 1'b0;
    sc = start_cnt;
    push(8'd20, 8'd64, 4'd2, 1'b1);
    wait_res_valid();
    push(8'd1, 8'd0, 4'd1, 1'b1);
    push(8'd100, 8'd125, 4'd4, 1'b1);
    push(8'd3, 8'd27, 4'd1, 1'b1);
    push(8'd200, 8'd216, 4'd5, 1'b1);
    check("t3_fifo_full", 32'(op_ready), 32'd0);
    cycles(10);
    check("t3_held_no_start", 32'(start_cnt - sc), 32'd1);
    check("t3_still_full", 32'(op_ready), 32'd0);
    res_ready = 1'b1;
    drain();
    check("t3_done_cnt", 32'(done_cnt), 32'd10);
    check("t3_no_err", 32'(err), 32'd0);

    // 4: func never acknowledges
    dead = 1'b1;
    push(8'd5, 8'd5, 4'd0, 1'b0);
    cycles(3);
    check("t4_err_before_expiry", 32'(err), 32'd0);
    cycles(1);
    check("t4_err_on_expiry", 32'(err), 32'd1);
    check("t4_no_result", 32'(res_valid), 32'd0);
    dead = 1'b0;
    push(8'd27, 8'd0, 4'd3, 1'b1);
    drain();
    check("t4_done_cnt", 32'(done_cnt), 32'd11);
    check("t4_err_sticky", 32'(err), 32'd1);

    // 5: asynchronous reset mid-RUN
    lat = 20;
    push(8'd9, 8'd1, 4'd0, 1'b0);
    wait_busy();
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_op_ready", 32'(op_ready), 32'd1);
    check("t5_f_start", 32'(f_start), 32'd0);
    check("t5_res", 32'({res_valid, res_y}), 32'd0);
    check("t5_done_cnt", 32'(done_cnt), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    check("t5_f_x", 32'({f_x1, f_x2}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lat = 3;
    sc = start_cnt;
    cycles(8);
    check("t5_fifo_empty", 32'(start_cnt - sc), 32'd0);
    push(8'd7, 8'd1, 4'd2, 1'b1);
    drain();
    check("t5_done_after", 32'(done_cnt), 32'd1);

    // 6: done_cnt wraps
    force dut.done_cnt = 16'hFFFF;
    cycles(1);
    release dut.done_cnt;
    check("t6_preload", 32'(done_cnt), 32'h0000FFFF);
    push(8'd0, 8'd1, 4'd1, 1'b1);
    drain();
    check("t6_wrap", 32'(done_cnt), 32'd0);

    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
